divu_hilo_unit: RTL and testbench
=================================

Name: divu_hilo_unit

Overview:
Multi-cycle unsigned divider with HI/LO register file in the EX stage. Directly downstream of the ALU control decoder: consumes its 4-bit ALUOperation code and services the three codes the single-cycle ALU does not: divu, mfhi and mflo. Issues a stall to the pipeline while a division is in flight. Returns HI or LO for mfhi/mflo.

Parameters:
WIDTH, 32, operand/quotient/remainder width
ALU_DIVU, 4'b0100, ALUOperation code that starts a divide
ALU_MFHI, 4'b1000, ALUOperation code that reads HI
ALU_MFLO, 4'b1001, ALUOperation code that reads LO

Ports:
clk  input  1  single system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  EX stage holds a valid (non-bubble) instruction
ALUOperation  input  4  operation code from ALU control
dividend  input  WIDTH  rs value (unsigned)
divisor  input  WIDTH  rt value (unsigned)
busy  output  1  divide in progress
stall  output  1  freeze IF/ID/EX, bubble MEM
hilo_out  output  WIDTH  HI for mfhi, LO for mflo, else 0
done  output  1  one-cycle pulse, HI/LO just written
div_zero  output  1  one-cycle pulse with done when divisor was 0
hi, lo  output  WIDTH  architectural HI/LO (debug/visibility)

Behaviour:
- Reset (rst=1 at edge): state IDLE; hi=lo=0; busy=done=div_zero=0; iteration counter, remainder, quotient and divisor registers cleared. Reset wins over every other event, including mid-divide (division aborted, HI/LO not written).
- States: IDLE, RUN.
- Issue: IDLE and en=1 and ALUOperation==ALU_DIVU at edge E0 -> latch quotient register=dividend, remainder=0, divisor reg=divisor, counter=WIDTH, state RUN. busy=1 from E0.
- RUN, each edge: restoring step on (WIDTH+1)-bit partial remainder: shift {rem,quot} left 1; if shifted rem >= divisor reg, subtract it and set quot LSB=1, else LSB=0; counter decrements.
- Completion: at edge E_WIDTH (the WIDTH-th step), hi<=final remainder, lo<=final quotient, state IDLE, busy=0, done=1 for the following cycle only. Latency: busy high exactly WIDTH cycles. A new divu is accepted in the cycle done is high.
- Divide by zero: no special datapath; restoring algorithm yields lo=all ones, hi=dividend. div_zero=1 alongside done when latched divisor was 0.
- Divide while busy: input ALUOperation/operands ignored in RUN; the pipeline holds them via stall.
- stall = busy & en & (ALUOperation in {ALU_DIVU, ALU_MFHI, ALU_MFLO}), combinational. Unrelated instructions are not stalled. The issuing divu itself sees stall=0 in cycle E0-1 and advances. mfhi/mflo behind it stall until busy falls.
- hilo_out combinational: ALUOperation==ALU_MFHI -> hi; ==ALU_MFLO -> lo; otherwise 0. Valid when stall=0. In the done cycle it already reflects the new HI/LO (no extra forwarding).
- en=0: no issue; stall=0; hilo_out still decoded.
- Operands and results are unsigned modulo 2^WIDTH. No exceptions raised.

Test Plan:
1. divu 100/7 at E0 -> busy high 32 cycles, done pulse, hi=2, lo=14, div_zero=0. Then mfhi -> hilo_out=2; mflo -> 14.
2. divu 0x00001234/0 -> lo=0xFFFFFFFF, hi=0x00001234, div_zero=1 with done for one cycle.
3. divu 0xFFFFFFFF/1 and 5/0xFFFFFFFF -> (hi=0, lo=0xFFFFFFFF) and (hi=5, lo=0).
4. divu issued, then mflo presented with en=1 two cycles later -> stall=1 until busy falls. Then hilo_out equals new lo with no stale value visible. An add (ALUOperation=0010) during busy -> stall=0.
5. Reset asserted at RUN cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse. A fresh divu 9/3 then gives hi=0, lo=3.
6. ALUOperation=ALU_DIVU with en=0 -> no busy, HI/LO unchanged. Back-to-back divu issued in done cycle -> accepted, second result correct.

Source files
------------

// File: rtl/divu_hilo_unit_if.sv
// Pipeline-side bundle for the multi-cycle unsigned divider and its HI/LO
// register file: EX-stage request, operands, stall/busy status and results.
interface divu_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             en;
  logic [3:0]       ALUOperation;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] hilo_out;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline / EX stage side
  modport master (
    output en, ALUOperation, dividend, divisor,
    input  busy, stall, hilo_out, done, div_zero, hi, lo
  );

  // Divider unit side
  modport slave (
    input  en, ALUOperation, dividend, divisor,
    output busy, stall, hilo_out, done, div_zero, hi, lo
  );
endinterface

// File: rtl/divu_hilo_unit.sv
// Multi-cycle restoring unsigned divider with architectural HI/LO registers.
// Services divu (start a WIDTH-step divide), mfhi and mflo for the EX stage,
// and stalls dependent instructions while a divide is in flight.
module divu_hilo_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [3:0]  ALU_DIVU = 4'b0100,
  parameter logic [3:0]  ALU_MFHI = 4'b1000,
  parameter logic [3:0]  ALU_MFLO = 4'b1001
) (
  input logic              clk,
  input logic              rst,
  divu_hilo_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   rem_q,      rem_d;
  logic [WIDTH-1:0]   quot_q,     quot_d;
  logic [WIDTH-1:0]   dvsr_q,     dvsr_d;
  logic [WIDTH-1:0]   hi_q,       hi_d;
  logic [WIDTH-1:0]   lo_q,       lo_d;
  logic               done_q,     done_d;
  logic               div_zero_q, div_zero_d;

  logic [WIDTH:0]     shifted_s;
  logic [WIDTH-1:0]   diff_s;
  logic               fits_s;
  logic [WIDTH-1:0]   step_rem_s;
  logic [WIDTH-1:0]   step_quot_s;
  logic               issue_s;
  logic               busy_s;
  logic               stall_s;
  logic [WIDTH-1:0]   hilo_out_s;

  // One restoring step: shift {rem,quot} left, subtract divisor when it fits.
  // The true difference is always below 2^WIDTH (rem < divisor invariant),
  // so a WIDTH-bit subtraction of the low bits yields the exact new remainder.
  always_comb begin
    shifted_s   = {rem_q, quot_q[WIDTH-1]};
    fits_s      = (shifted_s >= {1'b0, dvsr_q});
    diff_s      = shifted_s[WIDTH-1:0] - dvsr_q;
    if (fits_s) begin
      step_rem_s = diff_s;
    end else begin
      step_rem_s = shifted_s[WIDTH-1:0];
    end
    step_quot_s = {quot_q[WIDTH-2:0], fits_s};
  end

  // Issue decode: a valid divu seen while idle starts a new divide.
  always_comb begin
    issue_s = bus.en && (bus.ALUOperation == ALU_DIVU) && (state_q == IDLE);
  end

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          quot_d  = bus.dividend;
          rem_d   = {WIDTH{1'b0}};
          dvsr_d  = bus.divisor;
          cnt_d   = CNT_W'(WIDTH);
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        rem_d  = step_rem_s;
        quot_d = step_quot_s;
        cnt_d  = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          // Last step: commit results; divide-by-zero falls out naturally
          // as quotient all ones and remainder equal to the dividend.
          hi_d       = step_rem_s;
          lo_d       = step_quot_s;
          done_d     = 1'b1;
          div_zero_d = (dvsr_q == {WIDTH{1'b0}});
          state_d    = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any divide in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      rem_q      <= {WIDTH{1'b0}};
      quot_q     <= {WIDTH{1'b0}};
      dvsr_q     <= {WIDTH{1'b0}};
      hi_q       <= {WIDTH{1'b0}};
      lo_q       <= {WIDTH{1'b0}};
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Pipeline-facing decode: stall only HI/LO-dependent ops while busy, and
  // return HI/LO straight from the registers (already updated in done cycle).
  always_comb begin
    busy_s = (state_q == RUN);
    if (busy_s && bus.en &&
        ((bus.ALUOperation == ALU_DIVU) ||
         (bus.ALUOperation == ALU_MFHI) ||
         (bus.ALUOperation == ALU_MFLO))) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
    case (bus.ALUOperation)
      ALU_MFHI: hilo_out_s = hi_q;
      ALU_MFLO: hilo_out_s = lo_q;
      default:  hilo_out_s = {WIDTH{1'b0}};
    endcase
  end

  assign bus.busy     = busy_s;
  assign bus.stall    = stall_s;
  assign bus.hilo_out = hilo_out_s;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Self-checking bench for divu_hilo_unit: directed corner cases plus random
// divides checked against plain-arithmetic quotient/remainder.
module tb_divu_hilo_unit;

  localparam int unsigned W       = 32;
  localparam logic [3:0]  OP_DIVU = 4'b0100;
  localparam logic [3:0]  OP_MFHI = 4'b1000;
  localparam logic [3:0]  OP_MFLO = 4'b1001;
  localparam logic [3:0]  OP_ADD  = 4'b0010;
  localparam logic [3:0]  OP_NONE = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;
  logic        exp_dz;

  divu_hilo_unit_if #(.WIDTH(W)) bus ();

  divu_hilo_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: unsigned division; divide by zero gives all-ones / dividend.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    ref_div(a, b, exp_lo, exp_hi);
    exp_dz           = (b == 32'd0);
    bus.en           = 1'b1;
    bus.ALUOperation = OP_DIVU;
    bus.dividend     = a;
    bus.divisor      = b;
    #1;
    check("issue_stall", {31'd0, bus.stall}, 32'd0);
    step();
    check("busy_after_issue", {31'd0, bus.busy}, 32'd1);
    bus.en           = 1'b0;
    bus.ALUOperation = OP_NONE;
    bus.dividend     = $urandom;
    bus.divisor      = $urandom;
  endtask

  // Waits (bounded) for busy to fall; returns in the done cycle.
  task automatic finish_div(input string tag);
    int cycles = 1;
    int guard  = 0;
    while (bus.busy === 1'b1 && guard < 40) begin
      step();
      guard++;
      if (bus.busy === 1'b1) cycles++;
    end
    check({tag, "_busy_cycles"}, cycles, 32'd32);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check({tag, "_div_zero"}, {31'd0, bus.div_zero}, {31'd0, exp_dz});
    check({tag, "_hi"}, bus.hi, exp_hi);
    check({tag, "_lo"}, bus.lo, exp_lo);
  endtask

  // Done must drop after one cycle; then mfhi/mflo/add read back.
  task automatic read_back(input string tag);
    bus.en           = 1'b0;
    bus.ALUOperation = OP_NONE;
    step();
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_dz_pulse"}, {31'd0, bus.div_zero}, 32'd0);
    bus.en           = 1'b1;
    bus.ALUOperation = OP_MFHI;
    #1;
    check({tag, "_mfhi"}, bus.hilo_out, exp_hi);
    check({tag, "_mfhi_stall"}, {31'd0, bus.stall}, 32'd0);
    bus.ALUOperation = OP_MFLO;
    #1;
    check({tag, "_mflo"}, bus.hilo_out, exp_lo);
    bus.ALUOperation = OP_ADD;
    #1;
    check({tag, "_add_out"}, bus.hilo_out, 32'd0);
    bus.en           = 1'b0;
    bus.ALUOperation = OP_MFHI;
    #1;
    check({tag, "_mfhi_en0"}, bus.hilo_out, exp_hi);
    bus.ALUOperation = OP_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] saved_hi;
    logic [31:0] saved_lo;
    int          stall_cnt;
    int          guard;

    bus.en           = 1'b0;
    bus.ALUOperation = OP_NONE;
    bus.dividend     = 32'd0;
    bus.divisor      = 32'd0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dz", {31'd0, bus.div_zero}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    rst = 1'b0;
    step();

    // Directed divides: basic, divide by zero, extremes
    start_div(32'd100, 32'd7);
    finish_div("d100_7");
    read_back("d100_7");
    start_div(32'h0000_1234, 32'd0);
    finish_div("dzero");
    read_back("dzero");
    start_div(32'hFFFF_FFFF, 32'd1);
    finish_div("dmax_1");
    read_back("dmax_1");
    start_div(32'd5, 32'hFFFF_FFFF);
    finish_div("d5_max");
    read_back("d5_max");

    // Random divides with a spread of divisor magnitudes
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 255);
        2:       b = $urandom;
        default: b = a >> $urandom_range(0, 31);
      endcase
      start_div(a, b);
      finish_div("rand");
      read_back("rand");
    end

    // Stall behaviour: add not stalled, mflo stalled until busy falls
    a = $urandom;
    b = $urandom_range(1, 1000);
    start_div(a, b);
    bus.en           = 1'b1;
    bus.ALUOperation = OP_ADD;
    #1;
    check("add_no_stall", {31'd0, bus.stall}, 32'd0);
    step();
    bus.ALUOperation = OP_MFLO;
    stall_cnt        = 0;
    guard            = 0;
    #1;
    while (bus.busy === 1'b1 && guard < 40) begin
      if (bus.stall === 1'b1) stall_cnt++;
      step();
      guard++;
    end
    check("mflo_stall_cycles", stall_cnt, 32'd31);
    check("mflo_stall_release", {31'd0, bus.stall}, 32'd0);
    check("mflo_fresh_lo", bus.hilo_out, exp_lo);
    check("mflo_done", {31'd0, bus.done}, 32'd1);
    read_back("stall");

    // Reset in the middle of a divide
    start_div(32'hDEAD_BEEF, 32'd13);
    repeat (8) step();
    check("mid_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    repeat (30) step();
    check("abort_no_done", {31'd0, bus.done}, 32'd0);
    check("abort_lo_held", bus.lo, 32'd0);
    start_div(32'd9, 32'd3);
    finish_div("d9_3");
    read_back("d9_3");

    // divu with en=0 must not issue
    saved_hi         = bus.hi;
    saved_lo         = bus.lo;
    bus.en           = 1'b0;
    bus.ALUOperation = OP_DIVU;
    bus.dividend     = 32'd77;
    bus.divisor      = 32'd5;
    step();
    check("en0_busy", {31'd0, bus.busy}, 32'd0);
    step();
    check("en0_hi", bus.hi, saved_hi);
    check("en0_lo", bus.lo, saved_lo);
    check("en0_done", {31'd0, bus.done}, 32'd0);
    bus.ALUOperation = OP_NONE;

    // Back-to-back: second divu issued in the done cycle of the first
    start_div($urandom, $urandom_range(1, 65535));
    finish_div("b2b_first");
    start_div($urandom, $urandom_range(1, 65535));
    finish_div("b2b_second");
    read_back("b2b_second");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
